// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int STALL_CNT_W = 16;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Owner-tag delay line: tells the arbiter which port a returning read belongs to.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage_r [DEPTH];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= OWN_NONE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed D-priority arbiter with fetch starvation guard sharing one memory port.
// Optional stall statistics counter enabled by defining ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [DATA_W-1:0]      i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [DATA_W-1:0]      d_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-3:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_r;
    logic       i_gnt_s;
    logic       d_gnt_s;
    owner_t     tag_in_s;
    owner_t     tag_out_s;
    logic       unused_addr_bits_s;

    // Grant decision: D wins contention until fetch has waited STARVE_MAX grants.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!reset) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (i_req && d_req) begin
            if (starve_r >= STARVE_LIM) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Count D grants taken while fetch waits; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_r <= 4'd0;
        end else if (i_gnt_s || !i_req) begin
            starve_r <= 4'd0;
        end else if (d_gnt_s) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Memory-side mux; address and write data idle at zero when no access.
    always_comb begin
        mem_en    = i_gnt_s | d_gnt_s;
        mem_we    = d_gnt_s & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt_s) begin
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = d_wdata;
        end else if (i_gnt_s) begin
            mem_addr  = i_addr[ADDR_W-1:2];
        end else begin
            mem_addr  = '0;
        end
    end

    // Only reads get a tag; stores finish in their grant cycle.
    always_comb begin
        tag_in_s = OWN_NONE;
        if (d_gnt_s && !d_we) begin
            tag_in_s = OWN_D;
        end else if (i_gnt_s) begin
            tag_in_s = OWN_I;
        end else begin
            tag_in_s = OWN_NONE;
        end
    end

    mem_arb_resp_pipe #(
        .DEPTH (MEM_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign i_gnt    = i_gnt_s;
    assign d_gnt    = d_gnt_s;
    // Gate with reset so a tag reaching the output during the reset cycle is dropped.
    assign i_rvalid = reset & (tag_out_s == OWN_I);
    assign d_rvalid = reset & (tag_out_s == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    assign unused_addr_bits_s = ^{i_addr[1:0], d_addr[1:0]};

`ifdef ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_r;

    // Saturating count of cycles fetch is requesting but not granted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_r <= 16'd0;
        end else if (i_req && !i_gnt_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = '0;
`endif

endmodule
